// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic plus iterative shift-add multiply and restoring divide.
// Define ALU_MC_DIV_EN to build the divider (DIVU/DIVS/REMU); without it those opcodes report illegal.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         src0,
  input  logic [WIDTH-1:0]         src1,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     ov,
  output logic                     zr,
  output logic                     neg,
  output logic                     dz,
  output logic                     ill
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ZERO_V   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_V   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MAX_V    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MIN_V    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO2_V  = {(2*WIDTH){1'b0}};
  localparam logic [SW-1:0]      CNT_LAST = SW'(WIDTH-1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_MULS = 4'd10;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_DIVS = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;
`endif

  typedef enum logic {IDLE_ST = 1'b0, ITER_ST = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] hi_r, lo_r, dvs_r;
  logic [SW-1:0]    cnt_r;
  logic             sneg_r;
  logic             done_r, ov_r, zr_r, neg_r, dz_r, ill_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH-1:0]   sum_s, diff_s, mag0_s, mag1_s;
  logic               signed_op_s, sgn0_s, sgn1_s;
  logic               sc_iter_s, sc_ov_s, sc_dz_s, sc_ill_s;
  logic [WIDTH-1:0]   sc_res_s, init_lo_s, init_dvs_s;
  logic [WIDTH:0]     madd_s;
  logic [WIDTH-1:0]   step_hi_s, step_lo_s, fin_res_s;
  logic [2*WIDTH-1:0] sprod_s;
  logic               fin_ov_s;
  logic               accept_s, load_s, out_ov_s, out_dz_s, out_ill_s;
  logic [WIDTH-1:0]   out_res_s;
`ifdef ALU_MC_DIV_EN
  logic               divov_r, divov_init_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   quo_s;
`endif

  function automatic logic [WIDTH-1:0] sat_fix(input logic [WIDTH-1:0] val,
                                               input logic ovf, input logic sgn);
    if (SAT != 0 && ovf) begin
      return sgn ? MIN_V : MAX_V;
    end else begin
      return val;
    end
  endfunction

  // Decode the incoming request: single-cycle results and iterative operand setup
  always_comb begin
    sum_s  = src1 + src0;
    diff_s = src1 - src0;
`ifdef ALU_MC_DIV_EN
    signed_op_s  = (op == OP_MULS) || (op == OP_DIVS);
    divov_init_s = (op == OP_DIVS) && (src1 == MIN_V) && (src0 == ONES_V);
`else
    signed_op_s  = (op == OP_MULS);
`endif
    sgn0_s     = signed_op_s & src0[WIDTH-1];
    sgn1_s     = signed_op_s & src1[WIDTH-1];
    mag0_s     = sgn0_s ? (ZERO_V - src0) : src0;
    mag1_s     = sgn1_s ? (ZERO_V - src1) : src1;
    sc_iter_s  = 1'b0;
    sc_res_s   = ZERO_V;
    sc_ov_s    = 1'b0;
    sc_dz_s    = 1'b0;
    sc_ill_s   = 1'b0;
    init_lo_s  = mag0_s;
    init_dvs_s = mag1_s;
    case (op)
      OP_ADD: begin
        sc_ov_s  = (src1[WIDTH-1] == src0[WIDTH-1]) && (sum_s[WIDTH-1] != src1[WIDTH-1]);
        sc_res_s = sat_fix(sum_s, sc_ov_s, src1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_ov_s  = (src1[WIDTH-1] != src0[WIDTH-1]) && (diff_s[WIDTH-1] != src1[WIDTH-1]);
        sc_res_s = sat_fix(diff_s, sc_ov_s, src1[WIDTH-1]);
      end
      OP_AND:  sc_res_s = src1 & src0;
      OP_NOR:  sc_res_s = ~(src1 | src0);
      OP_SLL:  sc_res_s = src1 << shamt;
      OP_SRL:  sc_res_s = src1 >> shamt;
      OP_SRA:  sc_res_s = $unsigned($signed(src1) >>> shamt);
      OP_OR:   sc_res_s = src1 | src0;
      OP_XOR:  sc_res_s = src1 ^ src0;
      OP_MULU, OP_MULS: sc_iter_s = 1'b1;
`ifdef ALU_MC_DIV_EN
      OP_DIVU, OP_DIVS, OP_REMU: begin
        if (src0 == ZERO_V) begin
          sc_dz_s  = 1'b1;
          sc_res_s = (op == OP_REMU) ? src1 : ONES_V;
        end else begin
          sc_iter_s  = 1'b1;
          init_lo_s  = mag1_s;
          init_dvs_s = mag0_s;
        end
      end
`endif
      default: sc_ill_s = 1'b1;
    endcase
  end

  // One iteration step; hi/lo hold {product} for multiply and {remainder, quotient} for divide
  always_comb begin
    madd_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}});
`ifdef ALU_MC_DIV_EN
    trial_s = {hi_r, lo_r[WIDTH-1]} - {1'b0, dvs_r};
    if (op_r == OP_MULU || op_r == OP_MULS) begin
      step_hi_s = madd_s[WIDTH:1];
      step_lo_s = {madd_s[0], lo_r[WIDTH-1:1]};
    end else if (!trial_s[WIDTH]) begin
      step_hi_s = trial_s[WIDTH-1:0];
      step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      step_hi_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
      step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
    end
    quo_s = sneg_r ? (ZERO_V - step_lo_s) : step_lo_s;
`else
    step_hi_s = madd_s[WIDTH:1];
    step_lo_s = {madd_s[0], lo_r[WIDTH-1:1]};
`endif
    sprod_s = sneg_r ? (ZERO2_V - {step_hi_s, step_lo_s}) : {step_hi_s, step_lo_s};
    case (op_r)
      OP_MULU: begin
        fin_res_s = step_lo_s;
        fin_ov_s  = |step_hi_s;
      end
      OP_MULS: begin
        fin_res_s = sprod_s[WIDTH-1:0];
        fin_ov_s  = sprod_s[2*WIDTH-1:WIDTH] != {WIDTH{sprod_s[WIDTH-1]}};
      end
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin
        fin_res_s = step_lo_s;
        fin_ov_s  = 1'b0;
      end
      OP_DIVS: begin
        fin_res_s = divov_r ? MAX_V : quo_s;
        fin_ov_s  = divov_r;
      end
      OP_REMU: begin
        fin_res_s = step_hi_s;
        fin_ov_s  = 1'b0;
      end
`endif
      default: begin
        fin_res_s = ZERO_V;
        fin_ov_s  = 1'b0;
      end
    endcase
  end

  // Next state and the values to publish on a done cycle
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    load_s    = 1'b0;
    out_res_s = result_r;
    out_ov_s  = ov_r;
    out_dz_s  = dz_r;
    out_ill_s = ill_r;
    case (state_r)
      IDLE_ST: begin
        if (start) begin
          accept_s = 1'b1;
          if (sc_iter_s) begin
            state_s = ITER_ST;
          end else begin
            state_s   = IDLE_ST;
            load_s    = 1'b1;
            out_res_s = sc_res_s;
            out_ov_s  = sc_ov_s;
            out_dz_s  = sc_dz_s;
            out_ill_s = sc_ill_s;
          end
        end else begin
          state_s = IDLE_ST;
        end
      end
      ITER_ST: begin
        if (cnt_r == CNT_LAST) begin
          state_s   = IDLE_ST;
          load_s    = 1'b1;
          out_res_s = fin_res_s;
          out_ov_s  = fin_ov_s;
          out_dz_s  = 1'b0;
          out_ill_s = 1'b0;
        end else begin
          state_s = ITER_ST;
        end
      end
      default: state_s = IDLE_ST;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE_ST;
    end else begin
      state_r <= state_s;
    end
  end

  // Iterative datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= 4'd0;
      hi_r    <= ZERO_V;
      lo_r    <= ZERO_V;
      dvs_r   <= ZERO_V;
      cnt_r   <= {SW{1'b0}};
      sneg_r  <= 1'b0;
`ifdef ALU_MC_DIV_EN
      divov_r <= 1'b0;
`endif
    end else if (accept_s) begin
      op_r    <= op;
      hi_r    <= ZERO_V;
      lo_r    <= init_lo_s;
      dvs_r   <= init_dvs_s;
      cnt_r   <= {SW{1'b0}};
      sneg_r  <= sgn0_s ^ sgn1_s;
`ifdef ALU_MC_DIV_EN
      divov_r <= divov_init_s;
`endif
    end else if (state_r == ITER_ST) begin
      hi_r  <= step_hi_s;
      lo_r  <= step_lo_s;
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Output registers: updated only on a done cycle, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r   <= 1'b0;
      result_r <= ZERO_V;
      ov_r     <= 1'b0;
      zr_r     <= 1'b0;
      neg_r    <= 1'b0;
      dz_r     <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      done_r <= load_s;
      if (load_s) begin
        result_r <= out_res_s;
        ov_r     <= out_ov_s;
        zr_r     <= ~|out_res_s;
        neg_r    <= out_res_s[WIDTH-1];
        dz_r     <= out_dz_s;
        ill_r    <= out_ill_s;
      end
    end
  end

  assign busy   = (state_r == ITER_ST);
  assign done   = done_r;
  assign result = result_r;
  assign ov     = ov_r;
  assign zr     = zr_r;
  assign neg    = neg_r;
  assign dz     = dz_r;
  assign ill    = ill_r;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a saturating and a wrapping instance share stimulus;
// expectations come from an integer reference model and are checked by a decoupled monitor.
module tb_alu_mc;

  typedef struct packed {
    logic [15:0] res;
    logic        ov;
    logic        dz;
    logic        ill;
    logic        iter;
    int          acc;
    int          done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  op, shamt;
  logic [15:0] src0, src1;
  logic        busy_w[2], done_w[2], ov_w[2], zr_w[2], neg_w[2], dz_w[2], ill_w[2];
  logic [15:0] res_w[2];

  exp_t        sbq[2][$];
  logic [20:0] hold[2];
  int          cyc = 0;
  int          next_free = 0;
  int          checks = 0;
  int          errors = 0;

  alu_mc #(.WIDTH(16), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .op(op), .src0(src0), .src1(src1), .shamt(shamt),
    .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .ov(ov_w[0]), .zr(zr_w[0]),
    .neg(neg_w[0]), .dz(dz_w[0]), .ill(ill_w[0]));

  alu_mc #(.WIDTH(16), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .op(op), .src0(src0), .src1(src1), .shamt(shamt),
    .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .ov(ov_w[1]), .zr(zr_w[1]),
    .neg(neg_w[1]), .dz(dz_w[1]), .ill(ill_w[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] sh, input bit sat);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r  = 0;
    case (o)
      4'd0, 4'd1: begin
        r = (o == 4'd0) ? sa + sb : sa - sb;
        if (r > 32767 || r < -32768) begin
          e.ov = 1'b1;
          if (sat) r = (r > 0) ? 32767 : -32768;
        end
      end
      4'd2: r = ua & ub;
      4'd3: r = ~(ua | ub);
      4'd4: r = ua << sh;
      4'd5: r = ua >> sh;
      4'd6: r = sa >>> sh;
      4'd7: r = ua | ub;
      4'd8: r = ua ^ ub;
      4'd9: begin r = ua * ub; e.ov = (r > 65535); e.iter = 1'b1; end
      4'd10: begin r = sa * sb; e.ov = (r > 32767 || r < -32768); e.iter = 1'b1; end
`ifdef ALU_MC_DIV_EN
      4'd11: if (ub == 0) begin e.dz = 1'b1; r = 65535; end else begin r = ua / ub; e.iter = 1'b1; end
      4'd12: begin
        if (ub == 0) begin e.dz = 1'b1; r = 65535; end
        else if (sa == -32768 && sb == -1) begin r = 32767; e.ov = 1'b1; e.iter = 1'b1; end
        else begin r = sa / sb; e.iter = 1'b1; end
      end
      4'd13: if (ub == 0) begin e.dz = 1'b1; r = ua; end else begin r = ua % ub; e.iter = 1'b1; end
`endif
      default: begin e.ill = 1'b1; r = 0; end
    endcase
    e.res = r[15:0];
    return e;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d actual %h required %h", name, k, cyc, act, req);
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    logic exp_busy, exp_done;
    if (rst) begin
      sbq[k].delete();
      hold[k] = '0;
    end else begin
      exp_busy = (sbq[k].size() > 0) && sbq[k][0].iter && (cyc > sbq[k][0].acc) && (cyc < sbq[k][0].done);
      exp_done = (sbq[k].size() > 0) && (sbq[k][0].done == cyc);
      chk("busy", k, 32'(busy_w[k]), 32'(exp_busy));
      chk("done", k, 32'(done_w[k]), 32'(exp_done));
      if (exp_done) begin
        e = sbq[k].pop_front();
        hold[k] = {e.res, e.ov, (e.res == 16'h0000), e.res[15], e.dz, e.ill};
      end
      chk("res_ov_zr_neg_dz_ill", k,
          32'({res_w[k], ov_w[k], zr_w[k], neg_w[k], dz_w[k], ill_w[k]}), 32'(hold[k]));
    end
  endtask

  // Monitor: samples both instances on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    exp_t e0, e1;
    while (cyc < next_free) tick();
    start = 1'b1; op = o; src1 = a; src0 = b; shamt = sh;
    e0 = model(o, a, b, sh, 1'b1);
    e1 = model(o, a, b, sh, 1'b0);
    e0.acc = cyc; e0.done = cyc + (e0.iter ? 17 : 1);
    e1.acc = cyc; e1.done = e0.done;
    sbq[0].push_back(e0);
    sbq[1].push_back(e1);
    next_free = e0.done;
    tick();
    start = 1'b0;
  endtask

  task automatic junk_start();
    start = 1'b1; op = 4'($urandom_range(0, 15)); src1 = 16'($urandom); src0 = 16'($urandom);
    tick();
    start = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog cycle %0d actual running required finished", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    logic [3:0] abort_op;
    rst = 1'b1; start = 1'b1; op = 4'd0; src0 = 16'h0001; src1 = 16'h0001; shamt = 4'd0;
    tick(); tick(); tick();
    start = 1'b0;
    rst = 1'b0;
    next_free = cyc;
    tick();

    issue(4'd0, 16'h7FF0, 16'h0020, 4'd0);
    issue(4'd1, 16'h8000, 16'h0001, 4'd0);
    issue(4'd10, 16'hFFFD, 16'h0007, 4'd0);
    issue(4'd12, 16'hFFF9, 16'h0002, 4'd0);
    issue(4'd12, 16'h8000, 16'hFFFF, 4'd0);
    issue(4'd11, 16'h1234, 16'h0000, 4'd0);
    issue(4'd6, 16'h8F00, 16'h0000, 4'd4);
    issue(4'd14, 16'h1234, 16'h5678, 4'd0);
    issue(4'd9, 16'h0123, 16'h0456, 4'd0);
    tick(); tick();
    junk_start();
    issue(4'd10, 16'h8000, 16'h8000, 4'd0);
    issue(4'd1, 16'h0005, 16'h0007, 4'd0);

`ifdef ALU_MC_DIV_EN
    abort_op = 4'd11;
`else
    abort_op = 4'd9;
`endif
    issue(abort_op, 16'hFFFF, 16'h0003, 4'd0);
    t = cyc - 1;
    while (cyc < t + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    next_free = cyc;
    tick();

    for (int n = 0; n < 150; n++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), 4'($urandom_range(0, 15)));
      if (cyc < next_free - 1 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 8)) tick();
        junk_start();
      end
    end

    for (int w = 0; w < 40 && (sbq[0].size() > 0 || sbq[1].size() > 0); w++) tick();
    tick();
    for (int k = 0; k < 2; k++) chk("drain", k, 32'(sbq[k].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal values are even and at least 8.
REQ-002 SHALL have parameter SAT, default 1; 1 means ADD/SUB saturate, 0 means ADD/SUB wrap.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 SHALL have port op, input, 4 bits: operation code.
REQ-007 SHALL have ports src0 and src1, inputs, WIDTH bits each: operands; result = src1 OP src0.
REQ-008 SHALL have port shamt, input, $clog2(WIDTH) bits: shift amount.
REQ-009 SHALL have port busy, output, 1 bit: an iterative operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, result is valid.
REQ-011 SHALL have port result, output, WIDTH bits: registered result.
REQ-012 SHALL have ports ov, zr, neg, dz, ill, outputs, 1 bit each: overflow, zero, negative, divide-by-zero, illegal op.

Function
REQ-013 SHALL decode op as: 0 ADD, 1 SUB, 2 AND, 3 NOR, 4 SLL, 5 SRL, 6 SRA, 7 OR, 8 XOR, 9 MULU, 10 MULS, 11 DIVU, 12 DIVS, 13 REMU; 14 and 15 are illegal.
REQ-014 SHALL accept start only while busy=0, latching op, src0, src1 and shamt; start while busy=1 SHALL be ignored.
REQ-015 SHALL implement a state machine IDLE -> ITER -> IDLE: single-cycle ops stay in IDLE; MUL/DIV/REM ops enter ITER.
REQ-016 Single-cycle ops (0-8, illegal, divide-by-zero): start accepted at cycle t SHALL produce done=1 and result at t+1, with busy never asserted.
REQ-017 Iterative ops SHALL use a radix-2 shift-add multiplier or a restoring divider, one bit per cycle: busy=1 during t+1..t+WIDTH, done=1 at t+WIDTH+1, busy=0 in that done cycle.
REQ-018 The done cycle SHALL accept a new start (back-to-back operation).
REQ-019 result and all flags SHALL hold their values from the done cycle until the next done.
REQ-020 ADD/SUB with SAT=1: on positive overflow result = 0x7F..F, on negative overflow result = 0x80..0, ov=1; with SAT=0 the result wraps and ov is still reported.
REQ-021 SRA SHALL sign-fill; SLL and SRL SHALL zero-fill.
REQ-022 MULU/MULS SHALL return the low WIDTH bits of the product; ov=1 when the full 2*WIDTH product is not representable (MULU: high half nonzero; MULS: high half is not a sign extension).
REQ-023 DIVU/REMU SHALL return the unsigned quotient and remainder respectively.
REQ-024 DIVS SHALL truncate toward zero: divide magnitudes, then negate if the operand signs differ.
REQ-025 DIVS of MIN / -1 SHALL return MAX with ov=1.
REQ-026 Divisor src0 = 0 on any divide op SHALL set dz=1 with result all ones (DIVU/DIVS) or result = src1 (REMU), completing in 1 cycle.
REQ-027 An illegal op SHALL set ill=1 with result 0, completing in 1 cycle.
REQ-028 zr SHALL equal NOR of result, neg SHALL equal result[WIDTH-1]; all flags SHALL update only on done.

Reset
REQ-029 On rst=1 the block SHALL return to IDLE with busy=0, done=0, result=0, and ov, zr, neg, dz, ill all 0; rst dominates start.
REQ-030 rst during ITER SHALL abort the operation with no done pulse; start is accepted again from the first cycle after rst deasserts.

Configuration
REQ-031 Macro ALU_MC_DIV_EN defined: ops 11-13 SHALL be implemented as specified above.
REQ-032 Macro ALU_MC_DIV_EN undefined: ops 11-13 SHALL behave as illegal (ill=1, result 0, 1 cycle) and the divider logic SHALL be absent; the port list is unchanged.

Verification
REQ-033 WIDTH=16, ADD src1=0x7FF0, src0=0x0020 -> at t+1 done=1, result=0x7FFF, ov=1; with SAT=0 the result is 0x8010, ov=1.
REQ-034 MULS src1=0xFFFD (-3), src0=0x0007 -> busy during t+1..t+16, done at t+17, result=0xFFEB, ov=0, neg=1.
REQ-035 DIVS src1=0xFFF9 (-7), src0=0x0002 -> result=0xFFFD; DIVS 0x8000/0xFFFF -> result=0x7FFF, ov=1.
REQ-036 DIVU src1=0x1234, src0=0 -> at t+1 dz=1, result=0xFFFF; a start issued mid-MULU is ignored and the original result is unchanged.
REQ-037 Back-to-back: start on the done cycle is accepted; rst at t+5 of a DIVU -> no done, all outputs are 0 the next cycle.
